// File: rtl/shift_reg.sv
// REG_WIDTH-bit shift register with serial shift-in, parallel load and an optional debug step enable.
// Define SHIFT_REG_SHIFTCNT_EN to add the saturating shiftCount output.
module shift_reg #(
    parameter int DEBUG     = 1,
    parameter int REG_WIDTH = -1,
    parameter int MSB_IN    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serialIn,
    input  logic [REG_WIDTH-1:0] parallelIn,
    output logic                 serialOut,
    output logic [REG_WIDTH-1:0] parallelOut,
    input  logic                 shiftEn,
    input  logic                 loadEn,
    input  logic                 dbg_clk_enable
`ifdef SHIFT_REG_SHIFTCNT_EN
    ,
    output logic [$clog2(REG_WIDTH+1)-1:0] shiftCount
`endif
);

    // No handshake: shiftEn and loadEn are per-cycle qualifiers that may stay high indefinitely.

    generate
        if (REG_WIDTH <= 0) begin : gen_bad_width
            $error("shift_reg: REG_WIDTH must be set to a positive value");
        end
    endgenerate

    logic                 ce;
    logic [REG_WIDTH-1:0] q;
    logic [REG_WIDTH-1:0] shifted;

    assign ce = (DEBUG != 0) ? dbg_clk_enable : 1'b1;

    generate
        if (REG_WIDTH == 1) begin : gen_w1
            assign shifted = serialIn;
        end else if (MSB_IN != 0) begin : gen_msb_in
            assign shifted = {serialIn, q[REG_WIDTH-1:1]};
        end else begin : gen_lsb_in
            assign shifted = {q[REG_WIDTH-2:0], serialIn};
        end
    endgenerate

    // Reset beats the debug enable so a halted core can still be cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ce) begin
            if (loadEn) begin
                q <= parallelIn;
            end else if (shiftEn) begin
                q <= shifted;
            end
        end
    end

    assign parallelOut = q;
    assign serialOut   = (MSB_IN != 0) ? q[0] : q[REG_WIDTH-1];

`ifdef SHIFT_REG_SHIFTCNT_EN
    localparam int CW = $clog2(REG_WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(REG_WIDTH);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (ce) begin
            if (loadEn) begin
                cnt <= '0;
            end else if (shiftEn && (cnt != CNT_MAX)) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign shiftCount = cnt;
`endif

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg: three configurations driven in lockstep against a
// behavioural model, with directed cases followed by random traffic.
module tb_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       serialIn;
    logic [7:0] parallelIn;
    logic       shiftEn;
    logic       loadEn;
    logic       dbgEn;

    logic       sOutA, sOutB, sOutC;
    logic [7:0] pOutA, pOutB;
    logic [0:0] pOutC;
`ifdef SHIFT_REG_SHIFTCNT_EN
    logic [3:0] cntA, cntB;
    logic [0:0] cntC;
`endif

    int nChecks = 0;
    int nFail   = 0;

    // Reference state: register contents and effective-shift counts per instance.
    logic [7:0] mA, mB;
    logic       mC;
    int         cA, cB, cC;

    always #5 clk = ~clk;

    shift_reg #(.DEBUG(1), .REG_WIDTH(8), .MSB_IN(1)) dutA (
        .clk(clk), .rst(rst), .serialIn(serialIn), .parallelIn(parallelIn),
        .serialOut(sOutA), .parallelOut(pOutA), .shiftEn(shiftEn), .loadEn(loadEn),
        .dbg_clk_enable(dbgEn)
`ifdef SHIFT_REG_SHIFTCNT_EN
        , .shiftCount(cntA)
`endif
    );

    shift_reg #(.DEBUG(1), .REG_WIDTH(8), .MSB_IN(0)) dutB (
        .clk(clk), .rst(rst), .serialIn(serialIn), .parallelIn(parallelIn),
        .serialOut(sOutB), .parallelOut(pOutB), .shiftEn(shiftEn), .loadEn(loadEn),
        .dbg_clk_enable(dbgEn)
`ifdef SHIFT_REG_SHIFTCNT_EN
        , .shiftCount(cntB)
`endif
    );

    shift_reg #(.DEBUG(0), .REG_WIDTH(1), .MSB_IN(1)) dutC (
        .clk(clk), .rst(rst), .serialIn(serialIn), .parallelIn(parallelIn[0:0]),
        .serialOut(sOutC), .parallelOut(pOutC), .shiftEn(shiftEn), .loadEn(loadEn),
        .dbg_clk_enable(dbgEn)
`ifdef SHIFT_REG_SHIFTCNT_EN
        , .shiftCount(cntC)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Width-8 register: the serial bit enters at one end, everything else moves one place.
    function automatic logic [7:0] modelNext(input logic [7:0] cur, input bit msbIn, input bit en);
        if (rst) return 8'h00;
        if (!en) return cur;
        if (loadEn) return parallelIn;
        if (!shiftEn) return cur;
        if (msbIn) return (cur >> 1) | (8'(serialIn) << 7);
        return (cur << 1) | 8'(serialIn);
    endfunction

    function automatic int countNext(input int cur, input bit en, input int width);
        if (rst) return 0;
        if (!en) return cur;
        if (loadEn) return 0;
        if (shiftEn && cur < width) return cur + 1;
        return cur;
    endfunction

    task automatic compareAll();
        check("A_par", 32'(pOutA), 32'(mA));
        check("A_ser", 32'(sOutA), 32'(mA[0]));
        check("B_par", 32'(pOutB), 32'(mB));
        check("B_ser", 32'(sOutB), 32'(mB[7]));
        check("C_par", 32'(pOutC), 32'(mC));
        check("C_ser", 32'(sOutC), 32'(mC));
`ifdef SHIFT_REG_SHIFTCNT_EN
        check("A_cnt", 32'(cntA), 32'(cA));
        check("B_cnt", 32'(cntB), 32'(cB));
        check("C_cnt", 32'(cntC), 32'(cC));
`endif
    endtask

    // Apply one cycle of inputs, advance the model with them, then compare after the edge.
    task automatic cycle(input logic r, input logic ld, input logic sh, input logic si,
                         input logic [7:0] pi, input logic en);
        rst        = r;
        loadEn     = ld;
        shiftEn    = sh;
        serialIn   = si;
        parallelIn = pi;
        dbgEn      = en;
        @(posedge clk);
        #1;
        mA = modelNext(mA, 1'b1, en);
        mB = modelNext(mB, 1'b0, en);
        if (rst) mC = 1'b0;
        else if (loadEn) mC = parallelIn[0];
        else if (shiftEn) mC = serialIn;
        cA = countNext(cA, en, 8);
        cB = countNext(cB, en, 8);
        cC = countNext(cC, 1'b1, 1);
        compareAll();
    endtask

    initial begin
        logic [7:0] stream;
        logic [7:0] held;
        mA = '0; mB = '0; mC = 1'b0; cA = 0; cB = 0; cC = 0;
        rst = 1'b1; loadEn = 1'b0; shiftEn = 1'b0; serialIn = 1'b0; parallelIn = '0; dbgEn = 1'b1;

        cycle(1, 0, 0, 0, 8'h00, 1);
        cycle(1, 0, 0, 1, 8'hFF, 0);
        check("reset_par", 32'(pOutA), 32'h0);

        // Parallel load; LSB of A5 is the next bit out when shifting toward LSB.
        cycle(0, 1, 0, 0, 8'hA5, 1);
        check("load_par", 32'(pOutA), 32'hA5);
        check("load_ser", 32'(sOutA), 32'h1);

        // Shift 1,0,1,1,0,0,0,0 from zero in both directions.
        cycle(1, 0, 0, 0, 8'h00, 1);
        stream = 8'b0000_1101;
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, stream[i], 8'h00, 1);
        check("stream_msb_in", 32'(pOutA), 32'h0D);
        check("stream_lsb_in", 32'(pOutB), 32'hB0);

        // Load wins when load and shift are both high.
        cycle(0, 1, 1, 1, 8'h3C, 1);
        check("load_over_shift", 32'(pOutA), 32'h3C);

        // Debug enable low freezes the DEBUG=1 instances; the DEBUG=0 one keeps shifting.
        held = pOutA;
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1'(i), 8'h00, 0);
        check("dbg_hold", 32'(pOutA), 32'(held));
        cycle(0, 0, 1, 1, 8'h00, 1);
        check("dbg_resume", 32'(pOutA), 32'((held >> 1) | 8'h80));

        // Reset clears even with the debug enable low.
        cycle(0, 1, 0, 0, 8'hFF, 1);
        cycle(1, 0, 1, 1, 8'h00, 0);
        check("rst_dbg_par", 32'(pOutA), 32'h0);
        check("rst_dbg_ser", 32'(sOutA), 32'h0);

`ifdef SHIFT_REG_SHIFTCNT_EN
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1'($urandom_range(0, 1)), 8'h00, 1);
        check("cnt_saturate", 32'(cntA), 32'd8);
        cycle(0, 1, 0, 0, 8'h5A, 1);
        check("cnt_load_clear", 32'(cntA), 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 40) == 0),
                  1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 4) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
